div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Iterative restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits beside the execute-stage ALU.
- It does not own a subtractor. Each iteration it drives the shared add_sub block's operands, then consumes the difference and carry-out that add_sub returns.
- Produces one 32-bit result per operation. Latency is 35 cycles in the normal case and 2 cycles for special cases.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- div_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  in  32  rs1 value; captured when start is accepted.
- divisor  in  32  rs2 value; captured when start is accepted.
- busy  out  1  high in PREP, ITER and FIX.
- done  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  32  quotient or remainder; held until the next accepted start.
- as_a  out  32  add_sub operand A.
- as_b  out  32  add_sub operand B.
- as_sel  out  1  add_sub add_sub_sel (1 = subtract).
- as_res  in  32  add_sub add_res.
- as_c  in  1  add_sub carry-out of bit 31 (1 = no borrow, i.e. A >= B unsigned).

Behaviour:
- Reset is asynchronous: state goes to IDLE and all registers clear. busy=0, done=0, result=0, as_a=0, as_b=0, as_sel=0. Reset mid-operation abandons the operation with no done pulse.
- IDLE:
  - start=1 captures dividend, divisor and div_op, then goes to PREP.
  - start is ignored in every other state.
- PREP (1 cycle):
  - Signed ops: take the absolute values of both operands. The sign flags are q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - Unsigned ops: both sign flags are 0.
  - Divisor == 0: quotient = 0xFFFFFFFF, remainder = original dividend; go to DONE.
  - Signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000, remainder = 0; go to DONE.
  - Otherwise: Q = |dividend|, R = 0, count = 0; go to ITER.
- ITER (exactly 32 cycles):
  - Shifted value S = {R[30:0], Q[31]}, with msb flag m = R[31].
  - Drive as_a = S, as_b = |divisor|, as_sel = 1.
  - If (m OR as_c): R <= as_res and the new quotient bit is 1.
  - Else: R <= S and the new quotient bit is 0.
  - Q <= {Q[30:0], new bit}; count increments.
  - After count 31, go to FIX.
  - Outside ITER, as_a = 0, as_b = 0, as_sel = 0.
- FIX (1 cycle):
  - Negate Q if q_neg; negate R if r_neg. Negation is two's complement using a local incrementer, not add_sub.
  - Select Q for DIV/DIVU and R for REM/REMU into result; go to DONE.
- DONE (1 cycle): done=1, busy=0; go to IDLE. result holds its value.
- Latency: with start sampled at edge E0, done is high in the cycle after E34 (35 edges). Special cases assert done after E1 (2 edges).
- Width: all arithmetic is 32-bit, wrapping. The m flag supplies the 33rd remainder bit, so no wider adder is needed.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in PREP, if |dividend| < |divisor| (unsigned compare), set Q = 0 and R = |dividend|, then skip ITER and go to FIX. done arrives 3 edges after start. Sign fixup still applies, so REM -3/7 = -3 and DIV -3/7 = 0.
- Undefined: such operations take the full 35-cycle path. Results are identical either way; only latency differs.

Test Plan:
1. DIVU 100/7 -> result 14; REMU 100/7 -> 2. done exactly 35 edges after start; busy high for cycles 1-34; as_sel high only for 32 cycles.
2. DIV 0xFFFFFF9C/7 -> 0xFFFFFFF2 (-14); REM same operands -> 0xFFFFFFFE (-2); DIV 100/0xFFFFFFF9 -> 0xFFFFFFF2.
3. DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each done 2 edges after start.
4. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/0xFFFFFFFE -> 1, REMU -> 1 (exercises the m path).
5. start pulsed at ITER cycle 5 -> ignored, original result unchanged. rst asserted at ITER cycle 10 -> busy, done and result go to 0 immediately with no done pulse. A following DIVU 9/3 -> 3 completes normally.
6. With DIV_EARLY_OUT_EN: DIVU 5/9 -> 0 with done 3 edges after start; REM 0xFFFFFFFD/7 -> 0xFFFFFFFD. Without the macro, the same results arrive at 35 edges.

Source files
------------

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter : iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// Owns no subtractor: during ITER it drives the shared add_sub block
// (as_a - as_b with as_sel=1) and consumes the difference (as_res) and the
// carry-out of bit 31 (as_c = 1 means A >= B unsigned).
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         request, sampled only in IDLE
//   div_op        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend      rs1, captured on accepted start
//   divisor       rs2, captured on accepted start
//   busy          high in PREP, ITER, FIX
//   done          one-cycle pulse, result valid in that cycle
//   result        quotient or remainder, held until overwritten
//   as_a, as_b    add_sub operands (zero outside ITER)
//   as_sel        add_sub subtract select (zero outside ITER)
//   as_res, as_c  add_sub difference and carry-out
//
// Latency: 35 edges normally, 2 edges for divide-by-zero / signed overflow.
// Optional macro DIV_EARLY_OUT_EN: when |dividend| < |divisor| the iteration
// phase is skipped (3 edges); results are unchanged.
// -----------------------------------------------------------------------------
module div_iter #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      div_op,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] as_a,
   output logic [XLEN-1:0] as_b,
   output logic            as_sel,
   input  logic [XLEN-1:0] as_res,
   input  logic            as_c
);

   localparam logic [XLEN-1:0]  ONE      = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN-1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   state_t            r_state;
   logic [1:0]        r_op;
   logic [XLEN-1:0]   r_dvd;
   logic [XLEN-1:0]   r_dvs;
   logic [XLEN-1:0]   r_q;
   logic [XLEN-1:0]   r_r;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_qneg;
   logic              r_rneg;
   logic              r_busy;
   logic              r_done;
   logic [XLEN-1:0]   r_result;

   logic              w_signed;
   logic [XLEN-1:0]   w_dvd_abs;
   logic [XLEN-1:0]   w_dvs_abs;
   logic              w_ovf;
   logic [XLEN-1:0]   w_s;
   logic              w_m;
   logic              w_take;
   logic [XLEN-1:0]   w_q_fix;
   logic [XLEN-1:0]   w_r_fix;

   // op[0]=0 selects the signed variants (DIV, REM)
   assign w_signed  = ~r_op[0];
   assign w_dvd_abs = (w_signed && r_dvd[XLEN-1]) ? (~r_dvd + ONE) : r_dvd;
   assign w_dvs_abs = (w_signed && r_dvs[XLEN-1]) ? (~r_dvs + ONE) : r_dvs;
   assign w_ovf     = w_signed && (r_dvd == MIN_NEG) && (r_dvs == '1);

   // Shifted partial remainder; w_m is the 33rd bit that falls out of R, and
   // when set the true value already exceeds any divisor, so subtract anyway.
   assign w_s    = {r_r[XLEN-2:0], r_q[XLEN-1]};
   assign w_m    = r_r[XLEN-1];
   assign w_take = w_m | as_c;

   assign w_q_fix = r_qneg ? (~r_q + ONE) : r_q;
   assign w_r_fix = r_rneg ? (~r_r + ONE) : r_r;

   always_comb begin
      as_a   = '0;
      as_b   = '0;
      as_sel = 1'b0;
      if (r_state == S_ITER) begin
         as_a   = w_s;
         as_b   = r_dvs;
         as_sel = 1'b1;
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_dvd    <= '0;
         r_dvs    <= '0;
         r_q      <= '0;
         r_r      <= '0;
         r_cnt    <= '0;
         r_qneg   <= 1'b0;
         r_rneg   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op    <= div_op;
                  r_dvd   <= dividend;
                  r_dvs   <= divisor;
                  r_busy  <= 1'b1;
                  r_state <= S_PREP;
               end
            end

            S_PREP: begin
               r_qneg <= w_signed & (r_dvd[XLEN-1] ^ r_dvs[XLEN-1]);
               r_rneg <= w_signed & r_dvd[XLEN-1];
               r_dvs  <= w_dvs_abs;
               if (r_dvs == '0) begin
                  r_result <= r_op[1] ? r_dvd : '1;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= S_DONE;
               end else if (w_ovf) begin
                  r_result <= r_op[1] ? '0 : MIN_NEG;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= S_DONE;
               end
`ifdef DIV_EARLY_OUT_EN
               else if (w_dvd_abs < w_dvs_abs) begin
                  r_q     <= '0;
                  r_r     <= w_dvd_abs;
                  r_state <= S_FIX;
               end
`endif
               else begin
                  r_q     <= w_dvd_abs;
                  r_r     <= '0;
                  r_cnt   <= '0;
                  r_state <= S_ITER;
               end
            end

            S_ITER: begin
               r_r   <= w_take ? as_res : w_s;
               r_q   <= {r_q[XLEN-2:0], w_take};
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_CNT) begin
                  r_state <= S_FIX;
               end
            end

            S_FIX: begin
               r_result <= r_op[1] ? w_r_fix : w_q_fix;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= S_DONE;
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter : directed self-checking bench for div_iter.
// Models the shared add_sub block, runs hand-computed vectors and checks
// result, latency, busy/as_sel activity, start-ignore and async reset.
// -----------------------------------------------------------------------------
module tb_div_iter;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  div_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [31:0] as_a;
   logic [31:0] as_b;
   logic        as_sel;
   logic [31:0] as_res;
   logic        as_c;

   logic [32:0] w_sum;

   int n_checks;
   int n_errors;
   int edges;
   int busy_cnt;
   int sel_cnt;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_EARLY_OUT_EN
   localparam int LAT_EARLY = 3;
`else
   localparam int LAT_EARLY = 35;
`endif

   div_iter #(
      .XLEN  (32),
      .CNT_W (5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .div_op   (div_op),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .as_a     (as_a),
      .as_b     (as_b),
      .as_sel   (as_sel),
      .as_res   (as_res),
      .as_c     (as_c)
   );

   // add_sub model: A - B as A + ~B + 1 when as_sel, else A + B
   assign w_sum  = as_sel ? ({1'b0, as_a} + {1'b0, ~as_b} + 33'd1)
                          : ({1'b0, as_a} + {1'b0, as_b});
   assign as_res = w_sum[31:0];
   assign as_c   = w_sum[32];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edges++;
      if (busy)   busy_cnt++;
      if (as_sel) sel_cnt++;
   endtask

   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      div_op   = op;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      edges    = 0;
      busy_cnt = 0;
      sel_cnt  = 0;
      tick();
      start = 1'b0;
   endtask

   // waits for done (bounded), checks latency and result, then lets DONE retire
   task automatic wait_done(input string tag, input logic [31:0] exp, input int exp_lat);
      while (!done && edges < 100) tick();
      chk({tag, "_lat"}, 32'(edges), 32'(exp_lat));
      chk({tag, "_res"}, result, exp);
      tick();
      chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
   endtask

   task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      start_op(op, a, b);
      wait_done(tag, exp, exp_lat);
   endtask

   initial begin
      int dcount;
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      start    = 1'b0;
      div_op   = 2'b00;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",   {31'd0, busy},   32'd0);
      chk("rst_done",   {31'd0, done},   32'd0);
      chk("rst_result", result,          32'd0);
      chk("rst_as_a",   as_a,            32'd0);
      chk("rst_as_b",   as_b,            32'd0);
      chk("rst_as_sel", {31'd0, as_sel}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: unsigned basics with activity profile
      run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 35);
      chk("divu_busy_cycles", 32'(busy_cnt), 32'd34);
      chk("divu_sel_cycles",  32'(sel_cnt),  32'd32);
      run("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 35);

      // 2: signed
      run("div_m100_7", OP_DIV, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 35);
      run("rem_m100_7", OP_REM, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 35);
      run("div_100_m7", OP_DIV, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 35);

      // 3: special cases
      run("divu_by0", OP_DIVU, 32'h00001234, 32'd0, 32'hFFFFFFFF, 2);
      chk("by0_sel_cycles", 32'(sel_cnt), 32'd0);
      run("remu_by0", OP_REMU, 32'h00001234, 32'd0,        32'h00001234, 2);
      run("rem_by0",  OP_REM,  32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 2);
      run("div_ovf",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
      run("rem_ovf",  OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2);

      // 4: extremes, m-flag path
      run("divu_max_1",  OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 35);
      run("divu_max_fe", OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        35);
      run("remu_max_fe", OP_REMU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        35);

      // 5a: start during ITER is ignored
      start_op(OP_DIVU, 32'd1000, 32'd10);
      repeat (5) tick();
      div_op   = OP_REMU;
      dividend = 32'd7;
      divisor  = 32'd0;
      start    = 1'b1;
      tick();
      start = 1'b0;
      wait_done("ignore_start", 32'd100, 35);

      // 5b: async reset mid-ITER
      start_op(OP_DIVU, 32'd100, 32'd7);
      repeat (10) tick();
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy",   {31'd0, busy},   32'd0);
      chk("mid_rst_done",   {31'd0, done},   32'd0);
      chk("mid_rst_result", result,          32'd0);
      chk("mid_rst_as_sel", {31'd0, as_sel}, 32'd0);
      #3 rst = 1'b0;
      dcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) dcount++;
      end
      chk("mid_rst_no_done", 32'(dcount), 32'd0);
      run("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 35);

      // 6: early-out candidates (latency depends on build)
      run("divu_5_9",  OP_DIVU, 32'd5,        32'd9, 32'd0,        LAT_EARLY);
      run("rem_m3_7",  OP_REM,  32'hFFFFFFFD, 32'd7, 32'hFFFFFFFD, LAT_EARLY);
      run("div_m3_7",  OP_DIV,  32'hFFFFFFFD, 32'd7, 32'd0,        LAT_EARLY);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
